dmem_port_arbiter: RTL and testbench

Two-requester arbiter for the single synchronous-read/byte-write port of a block RAM such as DMEM or IMEM port A. Requester 0 is the CPU X stage and requester 1 is a secondary master such as a bootloader or DMA engine. Requester 0 has fixed priority. A starvation counter forces a requester-1 slot after a bounded wait. The block issues the stall to requester 0 and returns tagged read data one cycle after each granted read.

---
 rtl/dmem_port_arbiter.sv | 54 +++++
 tb/tb_dmem_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: fixed-priority two-requester arbiter for a synchronous-read block RAM port with requester-1 starvation relief
module dmem_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [DW/8-1:0] we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  output logic            gnt0,
  output logic            stall0,
  output logic            rvalid0,
  input  logic            req1,
  input  logic [DW/8-1:0] we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout,
  output logic [3:0]      starve_cnt
);
  logic force_slot;
  always_comb begin
    force_slot = starve_cnt == 4'(STARVE_LIMIT);
    gnt0 = req0 & ~force_slot;
    gnt1 = req1 & (~req0 | force_slot);
    stall0 = req0 & ~gnt0;
    mem_en = gnt0 | gnt1;
    mem_we = gnt1 ? we1 : gnt0 ? we0 : '0;
    mem_addr = gnt1 ? addr1 : addr0;
    mem_din = gnt1 ? wdata1 : wdata0;
    rdata = mem_dout;
  end
  // counter only runs while requester 1 waits; reaching the limit forces exactly one slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      starve_cnt <= (!req1 || gnt1) ? '0 : force_slot ? starve_cnt : starve_cnt + 4'd1;
      rvalid0 <= gnt0 & ~|we0;
      rvalid1 <= gnt1 & ~|we1;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with RAM model and spec-level arbitration reference
module tb_dmem_port_arbiter;
  localparam int AW = 12, DW = 32, BW = 4, LIMIT = 4;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0;
  logic [BW-1:0] we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, stall0, rvalid0, rvalid1, mem_en;
  logic [DW-1:0] rdata, mem_din;
  logic [DW-1:0] mem_dout = 0;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0] starve_cnt;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [64];
  logic [DW-1:0] ref_mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr[5:0]];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr[5:0]][b*8 +: 8] = mem_din[b*8 +: 8];
    end
  end

  typedef struct {
    int owner;
    logic [DW-1:0] data;
    int due;
  } rd_t;
  rd_t q[$];
  int checks = 0, errors = 0, cyc = 0, wait1 = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  rd_t m;
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      if (q.size() == 0) chk("unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
      else begin
        m = q.pop_front();
        chk("rvalid_cycle", cyc, m.due);
        chk("rvalid0", {31'b0, rvalid0}, {31'b0, m.owner == 0});
        chk("rvalid1", {31'b0, rvalid1}, {31'b0, m.owner == 1});
        chk("rdata", rdata, m.data);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      chk("missing_rvalid", 32'h0, 32'h1);
    end
  end

  task automatic step(input logic r0, input logic [BW-1:0] w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic [BW-1:0] w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output logic g0, output logic g1, output logic og1, output logic [3:0] ocnt);
    logic f;
    logic [BW-1:0] w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    f = wait1 == LIMIT;
    g1 = r1 && (!r0 || f);
    g0 = r0 && !g1;
    og1 = gnt1;
    ocnt = starve_cnt;
    w = g1 ? w1 : g0 ? w0 : '0;
    a = g1 ? a1 : a0;
    d = g1 ? d1 : d0;
    chk("gnt0", {31'b0, gnt0}, {31'b0, g0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, g1});
    chk("stall0", {31'b0, stall0}, {31'b0, r0 && !g0});
    chk("mem_en", {31'b0, mem_en}, {31'b0, g0 || g1});
    chk("mem_we", {28'b0, mem_we}, {28'b0, w});
    chk("starve_cnt", {28'b0, starve_cnt}, 32'(wait1));
    if (g0 || g1) begin
      chk("mem_addr", {20'b0, mem_addr}, {20'b0, a});
      chk("mem_din", mem_din, d);
      if (w == 0) begin
        e = '{owner: g1 ? 1 : 0, data: ref_mem[a[5:0]], due: cyc + 1};
        q.push_back(e);
      end else
        for (int b = 0; b < BW; b++) if (w[b]) ref_mem[a[5:0]][b*8 +: 8] = d[b*8 +: 8];
    end
    wait1 = (!r1 || g1) ? 0 : (wait1 < LIMIT ? wait1 + 1 : wait1);
    @(posedge clk);
    #1;
  endtask

  logic g0, g1, og1, p0, p1, r0, r1;
  logic [3:0] ocnt;
  logic [BW-1:0] w0, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[32] = 32'h11111111; ref_mem[32] = 32'h11111111;
    ram[33] = 32'h22222222; ref_mem[33] = 32'h22222222;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("reset_rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("reset_cnt", {28'b0, starve_cnt}, 32'h0);
    rst = 1;
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    step(1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1, og1, ocnt);
    step(1, 4'h0, 12'h010, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 12'(i), 0, 1, 0, 12'h005, 0, g0, g1, og1, ocnt);
      chk("pattern_gnt1", {31'b0, og1}, {31'b0, i % 5 == 4});
      chk("pattern_cnt", {28'b0, ocnt}, 32'(i % 5));
    end
    step(0, 0, 0, 0, 1, 0, 12'h020, 0, g0, g1, og1, ocnt);
    step(1, 0, 12'h021, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    step(0, 0, 0, 0, 1, 4'h3, 12'h030, 32'h12345678, g0, g1, og1, ocnt);
    step(1, 4'h8, 12'h010, 32'hAA000000, 0, 0, 0, 0, g0, g1, og1, ocnt);
    step(1, 0, 12'h010, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    repeat (3) step(1, 0, 12'h021, 0, 1, 0, 12'h022, 0, g0, g1, og1, ocnt);
    chk("pre_reset_cnt", {28'b0, starve_cnt}, 32'h3);
    rst = 0;
    q.delete();
    wait1 = 0;
    #1;
    chk("async_rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("async_rvalid1", {31'b0, rvalid1}, 32'h0);
    chk("async_cnt", {28'b0, starve_cnt}, 32'h0);
    chk("reset_gnt0", {31'b0, gnt0}, 32'h1);
    chk("reset_gnt1", {31'b0, gnt1}, 32'h0);
    @(posedge clk);
    #1;
    chk("held_rvalid0", {31'b0, rvalid0}, 32'h0);
    chk("held_cnt", {28'b0, starve_cnt}, 32'h0);
    req0 = 0; req1 = 0;
    rst = 1;
    p0 = 0; p1 = 0;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0) begin
        r0 = $urandom_range(0, 3) != 0;
        w0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        a0 = 12'($urandom_range(0, 63));
        d0 = $urandom;
      end
      if (!p1) begin
        r1 = $urandom_range(0, 1) != 0;
        w1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        a1 = 12'($urandom_range(0, 63));
        d1 = $urandom;
      end
      step(r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, og1, ocnt);
      p0 = r0 && !g0;
      p1 = r1 && !g1;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1, og1, ocnt);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
